// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that feeds one of three BCD words (op1, op2, res) to a
// single serializer. Each transfer is a one-cycle launch pulse, a bounded wait
// for the completion pulse, and a one-cycle gap.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no transfer; grant the next pending source round-robin
// LAUNCH    | tx_start high for this single cycle
// WAIT_DONE | waiting for tx_done; abort when the timeout counter expires
// GAP       | one cycle with sel/tx_value/grant_id still held
module serial_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_op1,
    input  logic        req_op2,
    input  logic        req_res,
    input  logic [15:0] op1,
    input  logic [15:0] op2,
    input  logic [15:0] res,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic        tx_start,
    output logic        sel_op1,
    output logic        sel_op2,
    output logic        sel_res,
    output logic [15:0] tx_value,
    output logic [2:0]  pending,
    output logic [1:0]  grant_id,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    // The abort fires on the edge where the counter would reach TIMEOUT_CYCLES-1,
    // so the error pulse lands TIMEOUT_CYCLES cycles after the launch cycle.
    localparam logic [9:0] CNT_ABORT = 10'(TIMEOUT_CYCLES - 2);

    state_t      state;
    logic [1:0]  last_grant;
    logic [9:0]  wait_cnt;
    logic [1:0]  nxt_id;
    logic [2:0]  nxt_mask;
    logic [15:0] nxt_value;
    logic [2:0]  req_vec;
    logic [2:0]  clr_mask;
    logic        unused_busy;

    // tx_busy is status only and has no sequencing effect.
    assign unused_busy = tx_busy;
    assign req_vec     = {req_res, req_op2, req_op1};

    // Round-robin pick: search begins at the source after the last grant.
    always_comb begin
        nxt_id = 2'd0;
        case (last_grant)
            2'd0: begin
                if (pending[1])      nxt_id = 2'd1;
                else if (pending[2]) nxt_id = 2'd2;
                else                 nxt_id = 2'd0;
            end
            2'd1: begin
                if (pending[2])      nxt_id = 2'd2;
                else if (pending[0]) nxt_id = 2'd0;
                else                 nxt_id = 2'd1;
            end
            default: begin
                if (pending[0])      nxt_id = 2'd0;
                else if (pending[1]) nxt_id = 2'd1;
                else                 nxt_id = 2'd2;
            end
        endcase
    end

    // Decode the picked source into a select mask, snapshot word and flag clear.
    always_comb begin
        nxt_mask  = 3'b001;
        nxt_value = op1;
        case (nxt_id)
            2'd1:    begin nxt_mask = 3'b010; nxt_value = op2; end
            2'd2:    begin nxt_mask = 3'b100; nxt_value = res; end
            default: begin nxt_mask = 3'b001; nxt_value = op1; end
        endcase
        clr_mask = ((state == IDLE) && (pending != 3'b000)) ? nxt_mask : 3'b000;
    end

    // Sequencer with registered outputs; a request on the grant edge re-arms its flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pending     <= 3'b000;
            last_grant  <= 2'd2;
            wait_cnt    <= 10'd0;
            tx_start    <= 1'b0;
            sel_op1     <= 1'b0;
            sel_op2     <= 1'b0;
            sel_res     <= 1'b0;
            tx_value    <= 16'h0000;
            grant_id    <= 2'd3;
            timeout_err <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            pending     <= (pending & ~clr_mask) | req_vec;
            case (state)
                IDLE: begin
                    if (pending != 3'b000) begin
                        state                     <= LAUNCH;
                        grant_id                  <= nxt_id;
                        last_grant                <= nxt_id;
                        {sel_res, sel_op2, sel_op1} <= nxt_mask;
                        tx_value                  <= nxt_value;
                        tx_start                  <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state    <= WAIT_DONE;
                    wait_cnt <= 10'd0;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state <= GAP;
                    end else if (wait_cnt == CNT_ABORT) begin
                        state       <= GAP;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                GAP: begin
                    state    <= IDLE;
                    sel_op1  <= 1'b0;
                    sel_op2  <= 1'b0;
                    sel_res  <= 1'b0;
                    grant_id <= 2'd3;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: directed requests, a scoreboard of expected
// grants popped by a tx_start monitor, and a second instance with a short
// timeout for the abort path.
module tb_serial_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_op1 = 1'b0, req_op2 = 1'b0, req_res = 1'b0;
    logic [15:0] op1 = 16'h0, op2 = 16'h0, res = 16'h0;
    logic        tx_done = 1'b0;
    logic        tx_start, sel_op1, sel_op2, sel_res, timeout_err;
    logic [15:0] tx_value;
    logic [2:0]  pending;
    logic [1:0]  grant_id;

    logic        to_req_res = 1'b0;
    logic        to_tx_start, to_sel_op1, to_sel_op2, to_sel_res, to_timeout_err;
    logic [15:0] to_tx_value;
    logic [2:0]  to_pending;
    logic [1:0]  to_grant_id;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] val;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   n_start = 0;
    int   done_delay = 1;

    serial_tx_arbiter u_dut (
        .clk(clk), .reset(reset),
        .req_op1(req_op1), .req_op2(req_op2), .req_res(req_res),
        .op1(op1), .op2(op2), .res(res),
        .tx_busy(1'b0), .tx_done(tx_done),
        .tx_start(tx_start), .sel_op1(sel_op1), .sel_op2(sel_op2), .sel_res(sel_res),
        .tx_value(tx_value), .pending(pending), .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    serial_tx_arbiter #(.TIMEOUT_CYCLES(8)) u_to (
        .clk(clk), .reset(reset),
        .req_op1(1'b0), .req_op2(1'b0), .req_res(to_req_res),
        .op1(op1), .op2(op2), .res(res),
        .tx_busy(1'b0), .tx_done(1'b0),
        .tx_start(to_tx_start), .sel_op1(to_sel_op1), .sel_op2(to_sel_op2),
        .sel_res(to_sel_res), .tx_value(to_tx_value), .pending(to_pending),
        .grant_id(to_grant_id), .timeout_err(to_timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every launch pulse must match the next expected grant.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            exp_t e;
            n_start++;
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_tx_start: got grant %0d expected no launch (cycle %0d)", grant_id, cyc);
            end else begin
                e = sbq.pop_front();
                check("sb_grant_id", 32'(grant_id), 32'(e.id));
                check("sb_tx_value", 32'(tx_value), 32'(e.val));
                check("sb_sel", 32'({sel_res, sel_op2, sel_op1}), 32'(3'b001 << e.id));
            end
        end
    end

    // Serializer model: completion pulse done_delay cycles after each launch.
    always begin
        @(negedge clk);
        if (tx_start === 1'b1 && reset) begin
            repeat (done_delay) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
        end
    end

    task automatic pulse(input logic [2:0] m);
        @(posedge clk);
        #1 {req_res, req_op2, req_op1} = m;
        @(posedge clk);
        #1 {req_res, req_op2, req_op1} = 3'b000;
    endtask

    task automatic push(input logic [1:0] id, input logic [15:0] val);
        exp_t e;
        e.id  = id;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic wait_tx_start(input string name, output int c);
        bit seen = 0;
        c = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                seen = 1;
                c = cyc;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no tx_start expected one within 300 cycles", name);
        end
    endtask

    task automatic wait_idle(input string name);
        bit seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (grant_id == 2'd3 && pending == 3'b000 && !tx_start) seen = 1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got busy expected idle within 600 cycles", name);
        end
    endtask

    task automatic do_reset();
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        int  c1, c2, c3;
        int  starts_before;
        bit  seen;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_sel", 32'({sel_res, sel_op2, sel_op1}), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h3);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_tx_value", 32'(tx_value), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single transfer of op1 with a slow serializer
        op1 = 16'hFFFF;
        done_delay = 40;
        push(2'd0, 16'hFFFF);
        pulse(3'b001);
        @(negedge clk);
        check("single_pending_set", 32'(pending), 32'h1);
        check("single_no_early_start", 32'(tx_start), 32'h0);
        @(negedge clk);
        check("single_tx_start", 32'(tx_start), 32'h1);
        check("single_pending_clr", 32'(pending), 32'h0);
        @(negedge clk);
        check("single_start_one_cycle", 32'(tx_start), 32'h0);
        check("single_sel_held", 32'(sel_op1), 32'h1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (tx_done) seen = 1;
        end
        check("single_done_seen", 32'(seen), 32'h1);
        @(negedge clk);
        check("single_gap_grant", 32'(grant_id), 32'h0);
        check("single_gap_sel", 32'(sel_op1), 32'h1);
        @(negedge clk);
        check("single_idle_grant", 32'(grant_id), 32'h3);
        check("single_idle_sel", 32'({sel_res, sel_op2, sel_op1}), 32'h0);
        check("single_idle_value", 32'(tx_value), 32'hFFFF);

        // Timeout on the short-timeout instance
        @(posedge clk);
        #1 to_req_res = 1'b1;
        @(posedge clk);
        #1 to_req_res = 1'b0;
        seen = 0;
        c1 = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (to_tx_start) begin seen = 1; c1 = cyc; end
        end
        check("to_launch_seen", 32'(seen), 32'h1);
        seen = 0;
        c2 = -1;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (to_timeout_err) begin
                seen = 1;
                c2 = cyc;
                check("to_pending_dropped", 32'(to_pending), 32'h0);
                check("to_gap_grant", 32'(to_grant_id), 32'h2);
            end
        end
        check("to_err_seen", 32'(seen), 32'h1);
        check("to_err_latency", 32'(c2 - c1), 32'd8);
        @(negedge clk);
        check("to_err_one_cycle", 32'(to_timeout_err), 32'h0);
        check("to_idle_grant", 32'(to_grant_id), 32'h3);

        // Simultaneous requests from reset, fastest serializer
        do_reset();
        op1 = 16'h1234;
        op2 = 16'h7986;
        res = 16'h6590;
        done_delay = 1;
        push(2'd0, 16'h1234);
        push(2'd1, 16'h7986);
        push(2'd2, 16'h6590);
        pulse(3'b111);
        @(negedge clk);
        check("sim_pending_111", 32'(pending), 32'h7);
        wait_tx_start("sim_first", c1);
        check("sim_pending_110", 32'(pending), 32'h6);
        wait_tx_start("sim_second", c2);
        check("sim_pending_100", 32'(pending), 32'h4);
        check("sim_spacing_1", 32'(c2 - c1), 32'd4);
        wait_tx_start("sim_third", c3);
        check("sim_pending_000", 32'(pending), 32'h0);
        check("sim_spacing_2", 32'(c3 - c2), 32'd4);
        wait_idle("sim_idle");

        // Fairness: after op2, res precedes op1
        done_delay = 5;
        push(2'd1, 16'h7986);
        push(2'd2, 16'h6590);
        push(2'd0, 16'h1234);
        pulse(3'b010);
        wait_tx_start("fair_op2", c1);
        pulse(3'b101);
        @(negedge clk);
        check("fair_pending_101", 32'(pending), 32'h5);
        wait_idle("fair_idle");

        // Merge and re-request; operand change after snapshot
        done_delay = 20;
        op2 = 16'h4321;
        push(2'd1, 16'h4321);
        pulse(3'b010);
        wait_tx_start("merge_op2", c1);
        push(2'd0, 16'h1234);
        push(2'd1, 16'h5555);
        op2 = 16'h5555;
        pulse(3'b001);
        pulse(3'b001);
        pulse(3'b001);
        pulse(3'b010);
        @(negedge clk);
        check("merge_pending_011", 32'(pending), 32'h3);
        check("merge_snapshot_held", 32'(tx_value), 32'h4321);
        wait_idle("merge_idle");

        // Reset in WAIT_DONE with op1/op2 pending
        done_delay = 300;
        push(2'd2, 16'h6590);
        pulse(3'b100);
        wait_tx_start("rst_res", c1);
        pulse(3'b011);
        @(negedge clk);
        check("rstmid_pending_011", 32'(pending), 32'h3);
        #2 reset = 1'b0;
        #1;
        check("rstmid_pending", 32'(pending), 32'h0);
        check("rstmid_grant", 32'(grant_id), 32'h3);
        check("rstmid_sel", 32'({sel_res, sel_op2, sel_op1}), 32'h0);
        check("rstmid_value", 32'(tx_value), 32'h0);
        check("rstmid_tx_start", 32'(tx_start), 32'h0);
        check("rstmid_timeout_err", 32'(timeout_err), 32'h0);
        starts_before = n_start;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (timeout_err) seen = 1;
        end
        check("rstmid_no_restart", 32'(n_start - starts_before), 32'h0);
        check("rstmid_no_err", 32'(seen), 32'h0);
        check("sb_empty", 32'(sbq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion within 500000 time units");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_tx_arbiter.md
SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, WAIT_DONE cycles allowed before abort (range 2..1023, 10-bit counter).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 req_op1  input  1  one-cycle request: transmit op1.
REQ-005 req_op2  input  1  one-cycle request: transmit op2.
REQ-006 req_res  input  1  one-cycle request: transmit res.
REQ-007 op1, op2, res  input  16 each  candidate BCD words.
REQ-008 tx_busy  input  1  serializer busy (status only, no sequencing effect).
REQ-009 tx_done  input  1  serializer one-cycle completion pulse.
REQ-010 tx_start  output  1  one-cycle launch pulse to serializer btn_press.
REQ-011 sel_op1, sel_op2, sel_res  output  1 each  one-hot source select, held for whole transfer.
REQ-012 tx_value  output  16  snapshot of granted word, held for whole transfer.
REQ-013 pending  output  3  pending flags {res, op2, op1}.
REQ-014 grant_id  output  2  0=op1, 1=op2, 2=res, 3=none.
REQ-015 timeout_err  output  1  one-cycle pulse on transfer abort.

Function
REQ-016 Pending flag per source: set on edge where its req is high; cleared only on the edge its grant is taken; repeated requests while pending merge into one transfer.
REQ-017 Request for the source currently being transferred re-sets its flag; it is served again later.
REQ-018 FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
REQ-019 IDLE: pending==0 -> stay; else next edge -> LAUNCH, latch grant, sel one-hot, tx_value snapshot, clear granted flag.
REQ-020 Grant is round-robin: search starts at source after last_grant, order op1->op2->res->op1; last_grant updates on each grant.
REQ-021 LAUNCH: tx_start=1 for exactly this one cycle; next edge -> WAIT_DONE, timeout counter cleared.
REQ-022 WAIT_DONE: tx_done=1 -> GAP; else counter increments; counter reaching TIMEOUT_CYCLES-1 without tx_done -> GAP with timeout_err=1 that cycle; aborted request is dropped.
REQ-023 GAP: exactly one cycle, sel/tx_value/grant_id still held; next edge -> IDLE.
REQ-024 In IDLE, sel_*=0, grant_id=3; tx_value holds last snapshot.
REQ-025 tx_done outside WAIT_DONE ignored; tx_done in LAUNCH cycle ignored.
REQ-026 Latency: req sampled at edge k -> LAUNCH from edge k+1 (if IDLE) -> tx_start high in cycle k+1..k+2.
REQ-027 Back-to-back: min spacing between tx_start pulses = 4 cycles (LAUNCH, 1 WAIT_DONE, GAP, IDLE).
REQ-028 Simultaneous requests same edge: all flags set; served one per transfer in round-robin order.
REQ-029 op1/op2/res changes after snapshot do not affect tx_value during transfer.

Reset
REQ-030 Reset low: state=IDLE immediately, pending=0, last_grant=res (first search starts at op1), counter=0, tx_start=0, sel_*=0, tx_value=0, grant_id=3, timeout_err=0.
REQ-031 Reset mid-transfer aborts without timeout_err; pending requests discarded.

Verification
REQ-032 Single: op1=FFFF, pulse req_op1 at edge k -> tx_start one cycle at k+1, sel_op1=1, tx_value=FFFF, grant_id=0; tx_done after 40 cycles -> GAP, then IDLE, grant_id=3.
REQ-033 Simultaneous: req_op1/op2/res same edge, op2=7986, res=6590 -> three transfers op1, op2 (7986), res (6590) in order; pending 111->110->100->000.
REQ-034 Fairness: after op2 transfer, pending op1 and res both set -> res granted before op1.
REQ-035 Timeout: TIMEOUT_CYCLES=8, req_res, no tx_done -> timeout_err pulse 8 cycles after LAUNCH, pending[2]=0, back to IDLE.
REQ-036 Merge/re-request: req_op1 three times while op2 in flight -> one op1 transfer; req_op2 during own transfer -> second op2 transfer follows.
REQ-037 Reset: assert reset in WAIT_DONE with pending=011 -> all outputs at REQ-030 values asynchronously, no tx_start after release without new request.
